// File: rtl/shift_sequencer.sv
// Multi-cycle shifter sequencer: applies an external 1-bit shifter amt_in times to data_in.
// Optional SHIFT_SEQ_FLAGS_EN adds registered zero/negative flags (z_out, n_out) captured on entry to DONE.
module shift_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op_in,
  input  logic [3:0]  amt_in,
  input  logic [15:0] data_in,
  output logic [15:0] sh_in,
  output logic [1:0]  sh_op,
  input  logic [15:0] sh_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
`ifdef SHIFT_SEQ_FLAGS_EN
  output logic        z_out,
  output logic        n_out,
`endif
  output logic [1:0]  state_o
);

  // Handshake: start is a request sampled only while IDLE (busy=0); a start seen
  // while busy=1 (RUN or DONE) is dropped, never queued. done pulses for one cycle.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [1:0]  op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = data_in;
          op_d  = op_in;
          cnt_d = amt_in;
          // Zero amount or no-op code skips straight to completion.
          state_d = ((amt_in != 4'd0) && (op_in != 2'b00)) ? RUN : DONE;
        end
      end
      RUN: begin
        acc_d = sh_out;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign sh_in   = acc_q;
  assign sh_op   = (state_q == RUN) ? op_q : 2'b00;
  assign result  = acc_q;
  assign state_o = state_q;

`ifdef SHIFT_SEQ_FLAGS_EN
  logic z_q, n_q;

  // acc_d is the value acc will hold in DONE, whether arriving from IDLE or RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
    end else if ((state_d == DONE) && (state_q != DONE)) begin
      z_q <= (acc_d == 16'h0000);
      n_q <= acc_d[15];
    end
  end

  assign z_out = z_q;
  assign n_out = n_q;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural 1-bit shifter in the loop.
// Define SHIFT_SEQ_FLAGS_EN for both bench and RTL to also check z_out/n_out.
module tb_shift_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op_in;
  logic [3:0]  amt_in;
  logic [15:0] data_in;
  logic [15:0] sh_in;
  logic [1:0]  sh_op;
  logic [15:0] sh_out;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [1:0]  state_o;
`ifdef SHIFT_SEQ_FLAGS_EN
  logic        z_out;
  logic        n_out;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  shift_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op_in   (op_in),
    .amt_in  (amt_in),
    .data_in (data_in),
    .sh_in   (sh_in),
    .sh_op   (sh_op),
    .sh_out  (sh_out),
    .busy    (busy),
    .done    (done),
    .result  (result),
`ifdef SHIFT_SEQ_FLAGS_EN
    .z_out   (z_out),
    .n_out   (n_out),
`endif
    .state_o (state_o)
  );

  // External 1-bit shifter.
  always_comb begin
    case (sh_op)
      2'b01:   sh_out = {sh_in[14:0], 1'b0};
      2'b10:   sh_out = {1'b0, sh_in[15:1]};
      2'b11:   sh_out = {sh_in[15], sh_in[15:1]};
      default: sh_out = sh_in;
    endcase
  end

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for done, counting cycles from the current one; bounded.
  task automatic wait_done(input int cyc_in, output int cyc_out);
    int c;
    c = cyc_in;
    while (!done && c < 40) begin
      step();
      c++;
    end
    cyc_out = c;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},   {15'd0, busy},    16'h0);
    check({tag, "_done"},   {15'd0, done},    16'h0);
    check({tag, "_result"}, result,           16'h0);
    check({tag, "_sh_in"},  sh_in,            16'h0);
    check({tag, "_sh_op"},  {14'd0, sh_op},   16'h0);
    check({tag, "_state"},  {14'd0, state_o}, 16'h0);
`ifdef SHIFT_SEQ_FLAGS_EN
    check({tag, "_z"},      {15'd0, z_out},   16'h0);
    check({tag, "_n"},      {15'd0, n_out},   16'h0);
`endif
  endtask

  // Driver: one full operation from IDLE, checked against a hand-computed result.
  task automatic run_op(input string tag, input logic [15:0] d, input logic [1:0] op,
                        input logic [3:0] amt, input logic [15:0] exp_res, input int exp_lat);
    int cyc;
    logic [15:0] exp_v;
    exp_q.push_back(exp_res);
    start = 1'b1; data_in = d; op_in = op; amt_in = amt;
    step();
    start = 1'b0;
    check({tag, "_busy0"}, {15'd0, busy}, 16'h1);
    check({tag, "_shin0"}, sh_in, d);
    check({tag, "_shop0"}, {14'd0, sh_op}, (exp_lat > 0) ? {14'd0, op} : 16'h0);
    wait_done(0, cyc);
    check({tag, "_lat"}, cyc[15:0], exp_lat[15:0]);
    exp_v = exp_q.pop_front();
    check({tag, "_result"}, result, exp_v);
    check({tag, "_state_done"}, {14'd0, state_o}, 16'h2);
`ifdef SHIFT_SEQ_FLAGS_EN
    check({tag, "_z"}, {15'd0, z_out}, {15'd0, (exp_v == 16'h0)});
    check({tag, "_n"}, {15'd0, n_out}, {15'd0, exp_v[15]});
`endif
    step();
    check({tag, "_done_pulse"}, {15'd0, done}, 16'h0);
    check({tag, "_idle"}, {15'd0, busy}, 16'h0);
    check({tag, "_held"}, result, exp_v);
  endtask

  initial begin
    int cyc;
    logic saw_done;
    reset = 1'b1; start = 1'b0; op_in = 2'b00; amt_in = 4'd0; data_in = 16'h0;
    step();
    step();
    reset = 1'b0;
    check_reset_vals("reset");
    step();

    run_op("left4",   16'h0001, 2'b01, 4'd4,  16'h0010, 4);
    run_op("asr15",   16'h8000, 2'b11, 4'd15, 16'hFFFF, 15);
    run_op("lsr1",    16'h8001, 2'b10, 4'd1,  16'h4000, 1);
    run_op("nop7",    16'h8001, 2'b00, 4'd7,  16'h8001, 0);
    run_op("amt0",    16'h1234, 2'b01, 4'd0,  16'h1234, 0);
    run_op("asr4",    16'hF0F0, 2'b11, 4'd4,  16'hFF0F, 4);
    run_op("asr3pos", 16'h7F00, 2'b11, 4'd3,  16'h0FE0, 3);
    run_op("lsl15",   16'h0003, 2'b01, 4'd15, 16'h8000, 15);
    run_op("lsr_zero",16'h0001, 2'b10, 4'd1,  16'h0000, 1);

    // Start during RUN and during DONE is ignored; one cycle later it is accepted.
    start = 1'b1; data_in = 16'h0001; op_in = 2'b01; amt_in = 4'd4;
    step();
    start = 1'b0;
    step();
    start = 1'b1; data_in = 16'hFFFF; op_in = 2'b11; amt_in = 4'd1;
    step();
    start = 1'b0;
    check("ign_run_busy", {15'd0, busy}, 16'h1);
    check("ign_run_shop", {14'd0, sh_op}, 16'h1);
    wait_done(2, cyc);
    check("ign_run_lat", cyc[15:0], 16'd4);
    check("ign_run_result", result, 16'h0010);
    start = 1'b1; data_in = 16'hFFFF; op_in = 2'b00; amt_in = 4'd0;
    step();
    check("ign_done_idle", {15'd0, busy}, 16'h0);
    check("ign_done_nodone", {15'd0, done}, 16'h0);
    check("ign_done_result", result, 16'h0010);
    step();
    start = 1'b0;
    check("accept_after_done", {15'd0, done}, 16'h1);
    check("accept_result", result, 16'hFFFF);
    step();
    check("accept_pulse", {15'd0, done}, 16'h0);

    // Reset mid-RUN after 3 steps.
    start = 1'b1; data_in = 16'h0001; op_in = 2'b01; amt_in = 4'd8;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("midrun_acc", result, 16'h0008);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_vals("midrun_rst");
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    check("midrun_no_done", {15'd0, saw_done}, 16'h0);
    check("midrun_idle", {15'd0, busy}, 16'h0);

    run_op("post_rst", 16'h00F0, 2'b10, 4'd4, 16'h000F, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports listed clock and reset first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op_in  input  2  shift code: 00 none, 01 left, 10 logical right, 11 arithmetic right.
REQ-006 amt_in  input  4  shift amount, 0..15.
REQ-007 data_in  input  16  operand to shift.
REQ-008 sh_in  output  16  operand driven to the 1-bit shifter.
REQ-009 sh_op  output  2  code driven to the 1-bit shifter.
REQ-010 sh_out  input  16  1-bit-shifted value returned by the shifter (combinational from sh_in/sh_op).
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 result  output  16  final shifted value; valid from done, held until next accepted start.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 In IDLE with start=1: latch acc<=data_in, op<=op_in, cnt<=amt_in; next state RUN if amt_in!=0 and op_in!=00, else DONE.
REQ-016 In RUN each cycle: acc<=sh_out, cnt<=cnt-1; when cnt==1, next state DONE.
REQ-017 In DONE: done=1 for exactly that cycle; next state IDLE unconditionally.
REQ-018 Start SHALL be ignored in RUN and DONE; no queuing, latched operands unchanged.
REQ-019 sh_in SHALL equal acc in all states; sh_op SHALL equal latched op in RUN and 00 otherwise.
REQ-020 result SHALL equal acc; it changes only in RUN and on an accepted start.
REQ-021 Latency: with start sampled at edge k, done SHALL be high during the cycle after edge k+n, where n = amt_in for a nonzero shift, else 0 (done one cycle after start).
REQ-022 Bits shifted out are discarded; left/logical-right fill 0, arithmetic-right replicates bit 15 every step.
REQ-023 Start asserted in the same cycle done is high SHALL be ignored; it is accepted only the following cycle (IDLE).

Reset
REQ-024 Reset SHALL take priority over start and any in-flight operation, including mid-RUN.
REQ-025 After reset: state IDLE, acc=0, cnt=0, op=00, busy=0, done=0, result=0, sh_in=0, sh_op=00.

Configuration
REQ-026 Macro SHIFT_SEQ_FLAGS_EN: when defined, outputs z_out (1 bit) and n_out (1 bit) SHALL exist, registered on the edge entering DONE as z_out=(final acc==0), n_out=final acc[15], held until the next DONE, reset to 0.
REQ-027 Without SHIFT_SEQ_FLAGS_EN, z_out and n_out SHALL not exist; all other behaviour identical.

Verification
REQ-028 data_in=16'h0001, op=01, amt=4, start -> busy 4 RUN cycles, done pulse, result=16'h0010.
REQ-029 data_in=16'h8000, op=11, amt=15 -> result=16'hFFFF, done 15 cycles after first RUN cycle; with flag macro z_out=0, n_out=1.
REQ-030 data_in=16'h8001, op=10, amt=1 -> result=16'h4000; op=00 amt=7 -> done next cycle, result=16'h8001, sh_op stays 00.
REQ-031 Start pulsed during RUN with data_in=16'hFFFF -> ignored, original result unchanged; start during DONE cycle ignored, start one cycle later accepted.
REQ-032 Reset asserted mid-RUN (amt=8, after 3 steps) -> next cycle all outputs at reset values, no done pulse.
REQ-033 data_in=16'h0003, op=01, amt=15 -> result=16'h8000; then data_in=16'h0001, op=10, amt=1 -> result=0, z_out=1 with macro.
